mips_instr_encoder_loader: RTL and testbench

Writer-side counterpart of the MIPS control decode path: accepts a stream of instruction descriptors (class plus fields), encodes each into a 32-bit MIPS machine word, and writes it sequentially into instruction memory. It is used at bring-up and in test to fill the instruction memory that the fetch/decode path later reads. The block is a start/done load controller with a valid/ready input handshake and a one-stage registered encode pipeline.

---
 rtl/mips_instr_encoder_loader.sv | 158 +++++++++++++++
 tb/tb_mips_instr_encoder_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instr_encoder_loader
//  Description : Accepts a stream of MIPS instruction descriptors, encodes
//                each legal one into a 32-bit machine word and writes it to
//                consecutive instruction-memory words starting at BASE_ADDR.
//                Start/done load controller, valid/ready descriptor input,
//                one-stage registered encode/write pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_instr_encoder_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_count;      // legal words requested by this load
  logic [ADDR_W:0]   r_index;      // legal words written so far
  logic [ADDR_W:0]   w_index_next;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_legal;
  logic              w_accept_legal;
  logic              w_last;
  logic              w_start_load;
  logic              w_start_empty;

  // Handshake qualifiers: a descriptor is only ever consumed in LOAD.
  assign w_accept       = (r_state == S_LOAD) && in_valid;
  assign w_legal        = (in_class != 3'd6) && (in_class != 3'd7);
  assign w_accept_legal = w_accept && w_legal;
  assign w_index_next   = r_index + {{ADDR_W{1'b0}}, 1'b1};
  // r_index < r_count throughout LOAD, so the increment never overflows.
  assign w_last         = w_accept_legal && (w_index_next == r_count);
  assign w_start_load   = (r_state == S_IDLE) && start && (count != '0);
  assign w_start_empty  = (r_state == S_IDLE) && start && (count == '0);

  // Combinational field packing for the six supported instruction classes.
  always_comb begin
    w_word = '0;
    case (in_class)
      3'd0:    w_word = {C_OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    w_word = {C_OP_LW,    in_rs, in_rt, in_imm};
      3'd2:    w_word = {C_OP_SW,    in_rs, in_rt, in_imm};
      3'd3:    w_word = {C_OP_ADDI,  in_rs, in_rt, in_imm};
      3'd4:    w_word = {C_OP_BEQ,   in_rs, in_rt, in_imm};
      3'd5:    w_word = {C_OP_J,     in_target};
      default: w_word = '0;
    endcase
  end

  // Load controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-derived handshake/status outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_load) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered write port, word index, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_index    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= w_accept_legal;
      // done lines up with the final write, or follows an empty load by one cycle
      done    <= w_last || w_start_empty;
      if (w_start_load) begin
        r_count <= count;
        r_index <= '0;
      end
      if ((r_state == S_IDLE) && start) begin
        err <= 1'b0;
      end else if (w_accept && !w_legal) begin
        err <= 1'b1;
      end
      if (w_accept_legal) begin
        imem_addr  <= C_BASE + r_index[ADDR_W-1:0];
        imem_wdata <= w_word;
        r_index    <= w_index_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_instr_encoder_loader
//  Description : Self-checking bench for mips_instr_encoder_loader. Two
//                instances (base 0 and base 254) share one stimulus stream;
//                a behavioural model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_instr_encoder_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   count = '0;
  logic          in_valid = 1'b0;
  logic [2:0]    in_class = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]    in_funct = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;

  logic          rdy0, we0, busy0, done0, err0;
  logic [AW-1:0] addr0;
  logic [31:0]   data0;
  logic          rdy1, we1, busy1, done1, err1;
  logic [AW-1:0] addr1;
  logic [31:0]   data1;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] la0[$];
  logic [31:0]   ld0[$];
  logic [AW-1:0] la1[$];

  always #5 clk = ~clk;

  mips_instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(rdy0), .in_class(in_class),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(data0),
    .busy(busy0), .done(done0), .err(err0)
  );

  mips_instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(254)) dut1 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(rdy1), .in_class(in_class),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(data1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the opcode/field table.
  function automatic logic [31:0] enc(input int c, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn, input logic [15:0] imm,
                                      input logic [25:0] tgt);
    longint unsigned v, r, t, d, s;
    r = longint'(rs); t = longint'(rt); d = longint'(rd); s = longint'(sh);
    case (c)
      0: v = r * 2097152 + t * 65536 + d * 2048 + s * 64 + longint'(fn);
      1: v = 35 * 67108864 + r * 2097152 + t * 65536 + longint'(imm);
      2: v = 43 * 67108864 + r * 2097152 + t * 65536 + longint'(imm);
      3: v = 8 * 67108864 + r * 2097152 + t * 65536 + longint'(imm);
      4: v = 4 * 67108864 + r * 2097152 + t * 65536 + longint'(imm);
      5: v = 2 * 67108864 + longint'(tgt);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  // Behavioural model state: what the outputs must show this cycle.
  bit          armed = 0;
  bit          m_ld = 0, m_fin = 0, m_done = 0, m_we = 0, m_err = 0;
  int          m_rem = 0, m_idx = 0, m_widx = 0;
  logic [31:0] m_data = '0;

  // Compare both instances against the model, then advance the model
  // using the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready0", 32'(rdy0), 32'(m_ld));
      chk("busy0", 32'(busy0), 32'(m_ld | m_fin));
      chk("done0", 32'(done0), 32'(m_done));
      chk("err0", 32'(err0), 32'(m_err));
      chk("we0", 32'(we0), 32'(m_we));
      chk("in_ready1", 32'(rdy1), 32'(m_ld));
      chk("busy1", 32'(busy1), 32'(m_ld | m_fin));
      chk("done1", 32'(done1), 32'(m_done));
      chk("err1", 32'(err1), 32'(m_err));
      chk("we1", 32'(we1), 32'(m_we));
      if (m_we) begin
        chk("addr0", 32'(addr0), 32'(m_widx % 256));
        chk("data0", data0, m_data);
        chk("addr1", 32'(addr1), 32'((254 + m_widx) % 256));
        chk("data1", data1, m_data);
      end
    end
    if (we0) begin la0.push_back(addr0); ld0.push_back(data0); end
    if (we1) la1.push_back(addr1);

    if (rst) begin
      armed = 1;
      m_ld = 0; m_fin = 0; m_done = 0; m_we = 0; m_err = 0;
      m_rem = 0; m_idx = 0;
    end else begin
      m_we = 0; m_done = 0;
      if (m_ld) begin
        if (in_valid) begin
          if (in_class > 3'd5) begin
            m_err = 1;
          end else begin
            m_we   = 1;
            m_widx = m_idx;
            m_data = enc(int'(in_class), in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
            m_idx++;
            m_rem--;
            if (m_rem == 0) begin m_ld = 0; m_fin = 1; m_done = 1; end
          end
        end
      end else if (m_fin) begin
        m_fin = 0;
      end else if (start) begin
        m_err = 0;
        if (count != 0) begin m_ld = 1; m_rem = int'(count); m_idx = 0; end
        else m_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int c);
    start = 1'b1; count = (AW + 1)'(c);
    tick();
    start = 1'b0; count = (AW + 1)'($urandom);
  endtask

  task automatic send(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input int gap,
                      input bit poke);
    bit ok = 0;
    in_class = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_valid = 1'b1;
    if (poke) begin start = 1'b1; count = (AW + 1)'($urandom); end
    for (int k = 0; k < 50; k++) begin
      ok = rdy0;
      tick();
      if (ok) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    in_class = 3'($urandom); in_imm = 16'($urandom);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles at %0t", $time);
    end
    repeat (gap) tick();
  endtask

  task automatic send_rand(input bit legal_only, input int gap, input bit poke, output bit legal);
    logic [2:0] c;
    c = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
    legal = (c <= 3'd5);
    send(c, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
         16'($urandom), 26'($urandom), gap, poke);
  endtask

  task automatic rand_load(input int cnt, input bit legal_only, input int maxgap);
    int n = 0;
    bit lg;
    do_start(cnt);
    while (n < cnt) begin
      send_rand(legal_only, $urandom_range(0, maxgap), ($urandom_range(0, 7) == 0), lg);
      if (lg) n++;
    end
    repeat (2) tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_we", 32'(we0), 32'd0);
    chk("reset_addr", 32'(addr0), 32'd0);
    chk("reset_data", data0, 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    tick();

    // Back-to-back LW / RTYPE / J
    la0.delete(); ld0.delete();
    do_start(3);
    send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 0, 0);
    send(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0, 0, 0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 0, 0);
    chk("t1_done_with_last", 32'({done0, we0}), 32'b11);
    repeat (2) tick();
    chk("t1_nwrites", 32'(la0.size()), 32'd3);
    if (la0.size() == 3) begin
      chk("t1_w0", ld0[0], 32'h8C080004);
      chk("t1_w1", ld0[1], 32'h01095020);
      chk("t1_w2", ld0[2], 32'h08000010);
      chk("t1_a2", 32'(la0[2]), 32'd2);
    end

    // SW / ADDI / BEQ with two-cycle gaps
    la0.delete(); ld0.delete();
    do_start(3);
    send(3'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0, 2, 0);
    send(3'd3, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 2, 0);
    send(3'd4, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 2, 0);
    chk("t2_nwrites", 32'(la0.size()), 32'd3);
    if (la0.size() == 3) begin
      chk("t2_w0", ld0[0], 32'hAD090008);
      chk("t2_w1", ld0[1], 32'h20090005);
      chk("t2_w2", ld0[2], 32'h1109FFFF);
      chk("t2_a1", 32'(la0[1]), 32'd1);
    end

    // Illegal class in the middle
    la0.delete(); ld0.delete();
    do_start(2);
    send(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 0, 0);
    send(3'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 0, 0);
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 0, 0);
    repeat (2) tick();
    chk("t3_nwrites", 32'(la0.size()), 32'd2);
    chk("t3_err_sticky", 32'(err0), 32'd1);
    do_start(0);
    chk("t4_err_cleared", 32'(err0), 32'd0);
    chk("t4_empty_done", 32'({done0, we0}), 32'b10);
    tick();

    // start during LOAD is ignored
    do_start(2);
    start = 1'b1; count = 9'd5; tick(); start = 1'b0;
    send(3'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'd7, 16'd0, 26'd0, 0, 0);
    send(3'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'd7, 16'd0, 26'd0, 0, 0);
    chk("t4_done_after_2", 32'(done0), 32'd1);
    tick();

    // Wrap from base 254
    la1.delete();
    rand_load(4, 1, 0);
    chk("t5_nwrites", 32'(la1.size()), 32'd4);
    if (la1.size() == 4) begin
      chk("t5_a0", 32'(la1[0]), 32'd254);
      chk("t5_a1", 32'(la1[1]), 32'd255);
      chk("t5_a2", 32'(la1[2]), 32'd0);
      chk("t5_a3", 32'(la1[3]), 32'd1);
    end

    // Reset after 2 of 5 words
    la0.delete();
    do_start(5);
    send(3'd3, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 0, 0);
    send(3'd3, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd2, 26'd0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_outs", 32'({rdy0, we0, busy0, done0, err0}), 32'd0);
    chk("t6_rst_addr", 32'(addr0), 32'd0);
    tick();
    la0.delete();
    rand_load(3, 1, 0);
    chk("t6_reload_n", 32'(la0.size()), 32'd3);
    if (la0.size() == 3) chk("t6_reload_a0", 32'(la0[0]), 32'd0);

    // Randomized loads, then one long wrapping burst
    for (int i = 0; i < 25; i++) begin
      rand_load($urandom_range(1, 7), 0, 2);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_load(300, 0, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
